hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum data-memory wait cycles before forced release.
REQ-002 Parameter CNT_W, default 32: width of the stall performance counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 rs1_d, rs2_d  in  5 each  D-stage source registers.
REQ-006 rs1_e, rs2_e, rd_e  in  5 each  E-stage source and destination registers.
REQ-007 rd_m, rd_w  in  5 each  M-stage and W-stage destination registers.
REQ-008 regwrite_e, regwrite_m, regwrite_w  in  1 each  stage writes the register file.
REQ-009 load_e  in  1  E-stage instruction is a load.
REQ-010 pcsrc_e  in  1  E-stage branch or jump taken.
REQ-011 mem_req_m, mem_ready_m  in  1 each  M-stage data-memory request and ready handshake.
REQ-012 stall_f, stall_d, stall_e, stall_m  out  1 each  hold; drives the active-low en of the PC and pipeline registers (1 = hold).
REQ-013 flush_d, flush_e, flush_w  out  1 each  synchronous clear of D, E, W pipeline registers.
REQ-014 fwd_a_e, fwd_b_e  out  2 each  E-stage operand select: 00 register file, 01 W result, 10 M result.
REQ-015 mem_err  out  1  sticky memory-timeout flag.
REQ-016 stall_cnt  out  CNT_W  count of cycles with stall_f high.

Function
REQ-017 Stall, flush and forward outputs are combinational from inputs and state (zero-cycle latency).
REQ-018 Memory wait: mem_req_m & !mem_ready_m, in RUN or MEM_WAIT, asserts stall_f/d/e/m and flush_w; overrides all other stall and flush causes.
REQ-019 FSM states RUN and MEM_WAIT; RUN->MEM_WAIT on mem_req_m & !mem_ready_m; MEM_WAIT->RUN on mem_ready_m or on timeout.
REQ-020 Wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle; timeout occurs when it reaches MEM_TIMEOUT-1.
REQ-021 On timeout, stalls deassert in the same cycle (forced release), mem_err sets, and the FSM returns to RUN.
REQ-022 mem_err clears only on reset.
REQ-023 Load-use: load_e & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d) asserts stall_f, stall_d, flush_e.
REQ-024 Taken branch: pcsrc_e asserts flush_d and flush_e and suppresses load-use and RAW stalls in the same cycle.
REQ-025 While memory-frozen, a taken branch produces no flush; pcsrc_e is held and the flush applies in the release cycle.
REQ-026 Forwarding priority is M over W; a source equal to x0 is never forwarded.
REQ-027 stall_cnt increments each cycle stall_f = 1; it wraps at 2^CNT_W without saturating.

Reset
REQ-028 While rst_n = 0: FSM in RUN, wait counter 0, mem_err 0, stall_cnt 0.
REQ-029 Reset asserted mid-wait aborts MEM_WAIT immediately; combinational outputs then follow the RUN equations.

Configuration
REQ-030 With macro HAZARD_FWD_EN defined, forwarding per REQ-026 is active.
REQ-031 Without HAZARD_FWD_EN, fwd_a_e/fwd_b_e are tied to 00.
REQ-032 Without HAZARD_FWD_EN, a nonzero D-stage source matching rd_e (regwrite_e) or rd_m (regwrite_m) asserts stall_f, stall_d, flush_e.

Structure
REQ-033 Forward-select codes, FSM state encoding and timeout counter width live in a shared package, hazard_pkg.
REQ-034 Forwarding comparison logic is one sub-module, fwd_unit, instantiated only under HAZARD_FWD_EN.

Verification
REQ-035 Load-use: load_e = 1, rd_e = 5, rs1_d = 5 -> stall_f = stall_d = flush_e = 1 for one cycle; stall_cnt += 1.
REQ-036 Load-use plus branch: load_e = 1, rd_e = 5, rs2_d = 5, pcsrc_e = 1 -> flush_d = flush_e = 1, stall_f = 0.
REQ-037 Forward: rs1_e = 3, rd_m = 3, rd_w = 3, regwrite_m = regwrite_w = 1 -> fwd_a_e = 10; with rs1_e = 0 -> 00.
REQ-038 Memory wait: mem_req_m = 1, ready low 4 cycles -> all stalls high 4 cycles, flush_w high; release on ready, mem_err = 0.
REQ-039 Timeout: MEM_TIMEOUT = 8, ready never rises -> release after 8 wait cycles, mem_err = 1 until rst_n low.
REQ-040 No HAZARD_FWD_EN: regwrite_m = 1, rd_m = 7, rs2_d = 7 -> stall_f = 1, fwd_b_e = 00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam int WAIT_CNT_W = 16;

   // A source register matches a producer only if it is not x0 and the producer writes.
   function automatic logic src_hit(input logic [4:0] src, input logic [4:0] rd, input logic we);
      return (src != 5'd0) && we && (src == rd);
   endfunction

   function automatic fwd_sel_t fwd_pick(input logic [4:0] src, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic we_m,
                                         input logic we_w);
      if (src_hit(src, rd_m, we_m)) return FWD_M;
      if (src_hit(src, rd_w, we_w)) return FWD_W;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// E-stage operand forwarding select; the M-stage result takes priority over W.
import hazard_pkg::*;

module fwd_unit (
   input  logic [4:0] rs1_e,
   input  logic [4:0] rs2_e,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       regwrite_m,
   input  logic       regwrite_w,
   output logic [1:0] fwd_a_e,
   output logic [1:0] fwd_b_e
);

   always_comb begin
      fwd_a_e = fwd_pick(rs1_e, rd_m, rd_w, regwrite_m, regwrite_w);
      fwd_b_e = fwd_pick(rs2_e, rd_m, rd_w, regwrite_m, regwrite_w);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, load-use/RAW stalls, branch flush.
// Define HAZARD_FWD_EN to enable operand forwarding (otherwise RAW hazards stall).
//
// state       | meaning
// ST_RUN      | normal issue; a pending memory request without ready freezes and enters wait
// ST_MEM_WAIT | pipeline frozen on data memory; leaves on ready or forced timeout release
import hazard_pkg::*;

module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  logic [4:0]       rd_m,
   input  logic [4:0]       rd_w,
   input  logic             regwrite_e,
   input  logic             regwrite_m,
   input  logic             regwrite_w,
   input  logic             load_e,
   input  logic             pcsrc_e,
   input  logic             mem_req_m,
   input  logic             mem_ready_m,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   output logic [1:0]       fwd_a_e,
   output logic [1:0]       fwd_b_e,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [WAIT_CNT_W-1:0] TMO_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

   state_t                state, state_nxt;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  branch_pend;
   logic                  mem_stall, timeout, frozen, branch, load_use, raw_hit, hazard;

`ifdef HAZARD_FWD_EN
   logic raw_unused;
   assign raw_unused = regwrite_e;
   assign raw_hit    = 1'b0;

   fwd_unit u_fwd (
      .rs1_e      (rs1_e),
      .rs2_e      (rs2_e),
      .rd_m       (rd_m),
      .rd_w       (rd_w),
      .regwrite_m (regwrite_m),
      .regwrite_w (regwrite_w),
      .fwd_a_e    (fwd_a_e),
      .fwd_b_e    (fwd_b_e)
   );
`else
   logic fwd_unused;
   assign fwd_unused = ^{rs1_e, rs2_e, rd_w, regwrite_w};
   assign raw_hit    = src_hit(rs1_d, rd_e, regwrite_e) | src_hit(rs2_d, rd_e, regwrite_e) |
                       src_hit(rs1_d, rd_m, regwrite_m) | src_hit(rs2_d, rd_m, regwrite_m);
   assign fwd_a_e    = FWD_RF;
   assign fwd_b_e    = FWD_RF;
`endif

   always_comb begin
      mem_stall = mem_req_m & ~mem_ready_m;
      timeout   = (state == ST_MEM_WAIT) && mem_stall && (wait_cnt == TMO_LAST);
      frozen    = mem_stall & ~timeout;
      // A branch seen while frozen is replayed from branch_pend on the release cycle.
      branch    = (pcsrc_e | branch_pend) & ~frozen;
      load_use  = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
      hazard    = (load_use | raw_hit) & ~branch & ~frozen;

      stall_f   = frozen | hazard;
      stall_d   = frozen | hazard;
      stall_e   = frozen;
      stall_m   = frozen;
      flush_d   = branch;
      flush_e   = branch | hazard;
      flush_w   = frozen;

      state_nxt = state;
      case (state)
         ST_RUN:      if (mem_stall) state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (mem_ready_m || timeout) state_nxt = ST_RUN;
         default:     state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         branch_pend <= 1'b0;
         mem_err     <= 1'b0;
         stall_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= (state == ST_RUN) ? '0 : wait_cnt + 1'b1;
         branch_pend <= frozen & (pcsrc_e | branch_pend);
         mem_err     <= mem_err | timeout;
         stall_cnt   <= stall_cnt + CNT_W'(stall_f);
      end
   end

endmodule
